// File: rtl/score_keeper.sv
// Line-clear scorer: converts line counts to BCD points and adds them digit-serially into a saturating 4-digit score.
// Optional SCORE_LEVEL_EN keeps a BCD lines total and derives level from its tens digit.
module score_keeper #(
    parameter logic [15:0] PTS_1 = 16'h0010,
    parameter logic [15:0] PTS_2 = 16'h0030,
    parameter logic [15:0] PTS_3 = 16'h0050,
    parameter logic [15:0] PTS_4 = 16'h0080
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear_valid,
    input  logic [2:0]  clear_lines,
    output logic        clear_ready,
    input  logic        game_restart,
    output logic [15:0] score_out,
    output logic        score_updated,
    output logic        busy,
    output logic        saturated,
    output logic [3:0]  level
);

    // state | meaning
    // IDLE  | no add in flight, waiting for an event
    // ADD   | one BCD digit summed per clock, low digit first
    // DONE  | commit result, then chain into a pending event if any
    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t      state, state_next;
    logic [15:0] acc, op;
    logic [1:0]  digit;
    logic        carry;
    logic        pending_valid, pending_valid_next;
    logic [2:0]  pending_lines, start_lines;
    logic        start, store_pending;
    logic        lines_legal, accept_legal;
    logic [4:0]  dsum;
    logic [15:0] commit_score;

    function automatic logic [4:0] bcd_add_digit(input logic [3:0] a, input logic [3:0] b,
                                                 input logic cin);
        logic [4:0] sum;
        logic [4:0] adj;
        sum = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
        adj = sum - 5'd10;
        if (sum > 5'd9)
            return {1'b1, adj[3:0]};
        return sum;
    endfunction

    function automatic logic [15:0] pts_of(input logic [2:0] n);
        case (n)
            3'd1:    return PTS_1;
            3'd2:    return PTS_2;
            3'd3:    return PTS_3;
            3'd4:    return PTS_4;
            default: return 16'h0000;
        endcase
    endfunction

    // Illegal line counts still complete the handshake but are dropped here.
    assign lines_legal  = (clear_lines != 3'd0) && (clear_lines <= 3'd4);
    assign accept_legal = clear_valid && clear_ready && !game_restart && lines_legal;
    assign dsum         = bcd_add_digit(acc[3:0], op[3:0], carry);
    assign commit_score = carry ? 16'h9999 : acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next    = state;
        start         = 1'b0;
        start_lines   = clear_lines;
        store_pending = 1'b0;
        case (state)
            IDLE: begin
                if (accept_legal)
                    start = 1'b1;
            end
            ADD: begin
                if (digit == 2'd3)
                    state_next = DONE;
                if (accept_legal)
                    store_pending = 1'b1;
            end
            DONE: begin
                state_next = IDLE;
                if (pending_valid) begin
                    start       = 1'b1;
                    start_lines = pending_lines;
                end else if (accept_legal) begin
                    start = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
        if (start)
            state_next = ADD;
        if (game_restart) begin
            state_next    = IDLE;
            start         = 1'b0;
            store_pending = 1'b0;
        end
    end

    assign pending_valid_next = !game_restart &&
                                (store_pending || (pending_valid && state != DONE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc           <= 16'h0000;
            op            <= 16'h0000;
            digit         <= 2'd0;
            carry         <= 1'b0;
            score_out     <= 16'h0000;
            score_updated <= 1'b0;
            busy          <= 1'b0;
            saturated     <= 1'b0;
            pending_valid <= 1'b0;
            pending_lines <= 3'd0;
            clear_ready   <= 1'b1;
        end else if (game_restart) begin
            acc           <= 16'h0000;
            op            <= 16'h0000;
            digit         <= 2'd0;
            carry         <= 1'b0;
            score_out     <= 16'h0000;
            score_updated <= 1'b0;
            busy          <= 1'b0;
            saturated     <= 1'b0;
            pending_valid <= 1'b0;
            pending_lines <= 3'd0;
            clear_ready   <= 1'b1;
        end else begin
            // A chained add starts from the value being committed this edge.
            if (start) begin
                acc   <= (state == DONE) ? commit_score : score_out;
                op    <= pts_of(start_lines);
                digit <= 2'd0;
                carry <= 1'b0;
            end else if (state == ADD) begin
                acc   <= {dsum[3:0], acc[15:4]};
                op    <= {4'h0, op[15:4]};
                carry <= dsum[4];
                digit <= digit + 2'd1;
            end
            if (state == DONE) begin
                score_out <= commit_score;
                saturated <= saturated | carry;
            end
            score_updated <= (state == DONE);
            busy          <= (state_next != IDLE);
            pending_valid <= pending_valid_next;
            if (store_pending)
                pending_lines <= clear_lines;
            clear_ready <= !pending_valid_next;
        end
    end

`ifdef SCORE_LEVEL_EN
    logic [2:0] op_lines;
    logic [7:0] lines_total;
    logic [4:0] lt_lo, lt_hi;

    assign lt_lo = bcd_add_digit(lines_total[3:0], {1'b0, op_lines}, 1'b0);
    assign lt_hi = bcd_add_digit(lines_total[7:4], 4'h0, lt_lo[4]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_lines    <= 3'd0;
            lines_total <= 8'h00;
        end else if (game_restart) begin
            op_lines    <= 3'd0;
            lines_total <= 8'h00;
        end else begin
            if (start)
                op_lines <= start_lines;
            if (state == DONE)
                lines_total <= lt_hi[4] ? 8'h99 : {lt_hi[3:0], lt_lo[3:0]};
        end
    end

    assign level = lines_total[7:4];
`else
    assign level = 4'h0;
`endif

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper: vector table for single adds plus hand sequences for
// carry, saturation, buffering, restart and reset corner cases.
module tb_score_keeper;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear_valid = 1'b0;
    logic [2:0]  clear_lines = 3'd0;
    logic        clear_ready;
    logic        game_restart = 1'b0;
    logic [15:0] score_out;
    logic        score_updated;
    logic        busy;
    logic        saturated;
    logic [3:0]  level;

    int errors = 0;
    int checks = 0;
    int pulses = 0;

    score_keeper dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear_valid  (clear_valid),
        .clear_lines  (clear_lines),
        .clear_ready  (clear_ready),
        .game_restart (game_restart),
        .score_out    (score_out),
        .score_updated(score_updated),
        .busy         (busy),
        .saturated    (saturated),
        .level        (level)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (score_updated) pulses++;

    typedef struct {
        logic [2:0]  lines;
        logic [15:0] exp_score;
        int          exp_pulses;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        clear_valid  = 1'b0;
        game_restart = 1'b0;
        rst_n        = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic send(input logic [2:0] n);
        clear_valid = 1'b1;
        clear_lines = n;
        @(negedge clk);
        clear_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL wait_idle: busy still %b after %0d cycles, expected 0", busy, k);
        end
        @(negedge clk);
    endtask

    task automatic add_n(input logic [2:0] n, input int count);
        repeat (count) begin
            send(n);
            wait_idle();
        end
    endtask

    initial begin
        int p0;
        int bc;
        int w;
        logic dropped;

        vecs[0] = '{3'd4, 16'h0080, 1};
        vecs[1] = '{3'd3, 16'h0130, 1};
        vecs[2] = '{3'd0, 16'h0130, 0};
        vecs[3] = '{3'd2, 16'h0160, 1};
        vecs[4] = '{3'd5, 16'h0160, 0};
        vecs[5] = '{3'd1, 16'h0170, 1};
        vecs[6] = '{3'd7, 16'h0170, 0};
        vecs[7] = '{3'd4, 16'h0250, 1};

        @(negedge clk);
        do_reset();
        check("reset_score", score_out, 16'h0000);
        check("reset_busy", busy, 1'b0);
        check("reset_ready", clear_ready, 1'b1);
        check("reset_sat", saturated, 1'b0);
        check("reset_upd", score_updated, 1'b0);

        // single add: busy for five cycles, one update pulse
        send(3'd4);
        bc = 0;
        while (busy && bc < 20) begin
            bc++;
            @(negedge clk);
        end
        check("single_busy_cycles", bc, 5);
        check("single_score", score_out, 16'h0080);
        check("single_upd_hi", score_updated, 1'b1);
        @(negedge clk);
        check("single_upd_lo", score_updated, 1'b0);

        do_reset();
        for (int i = 0; i < 8; i++) begin
            p0 = pulses;
            send(vecs[i].lines);
            wait_idle();
            check($sformatf("vec%0d_score", i), score_out, vecs[i].exp_score);
            check($sformatf("vec%0d_pulses", i), pulses - p0, vecs[i].exp_pulses);
        end

        // carry chain 0990 + 10
        do_reset();
        add_n(3'd4, 12);
        add_n(3'd2, 1);
        check("carry_pre", score_out, 16'h0990);
        add_n(3'd1, 1);
        check("carry_score", score_out, 16'h1000);
        check("carry_sat", saturated, 1'b0);

        // saturation
        do_reset();
        add_n(3'd4, 124);
        add_n(3'd2, 1);
        check("sat_pre", score_out, 16'h9950);
        check("sat_pre_flag", saturated, 1'b0);
        add_n(3'd4, 1);
        check("sat_score", score_out, 16'h9999);
        check("sat_flag", saturated, 1'b1);
        p0 = pulses;
        add_n(3'd1, 1);
        check("sat_hold", score_out, 16'h9999);
        check("sat_pulse", pulses - p0, 1);

        // buffering: 1, 2, 3 lines back to back
        do_reset();
        p0 = pulses;
        dropped = 1'b0;
        clear_valid = 1'b1;
        clear_lines = 3'd1;
        @(negedge clk);
        clear_lines = 3'd2;
        @(negedge clk);
        check("buf_ready_low", clear_ready, 1'b0);
        clear_lines = 3'd3;
        w = 0;
        while (!clear_ready && w < 50) begin
            if (!busy) dropped = 1'b1;
            @(negedge clk);
            w++;
        end
        check("buf_third_wait", w, 4);
        @(negedge clk);
        clear_valid = 1'b0;
        bc = 0;
        while (busy && bc < 50) begin
            bc++;
            @(negedge clk);
        end
        check("buf_tail_busy", bc, 9);
        check("buf_busy_no_drop", dropped, 1'b0);
        @(negedge clk);
        check("buf_score", score_out, 16'h0090);
        check("buf_pulses", pulses - p0, 3);

        // game_restart during ADD with pending full
        clear_valid = 1'b1;
        clear_lines = 3'd4;
        @(negedge clk);
        clear_lines = 3'd1;
        @(negedge clk);
        clear_valid  = 1'b0;
        game_restart = 1'b1;
        @(negedge clk);
        game_restart = 1'b0;
        check("rst_score", score_out, 16'h0000);
        check("rst_busy", busy, 1'b0);
        check("rst_ready", clear_ready, 1'b1);
        check("rst_sat", saturated, 1'b0);
        p0 = pulses;
        repeat (8) @(negedge clk);
        check("rst_quiet_score", score_out, 16'h0000);
        check("rst_quiet_pulses", pulses - p0, 0);

        // event coincident with restart is dropped
        add_n(3'd2, 1);
        clear_valid  = 1'b1;
        clear_lines  = 3'd4;
        game_restart = 1'b1;
        @(negedge clk);
        clear_valid  = 1'b0;
        game_restart = 1'b0;
        check("rst_drop_busy", busy, 1'b0);
        repeat (6) @(negedge clk);
        check("rst_drop_score", score_out, 16'h0000);

        // async reset mid-add
        add_n(3'd2, 1);
        check("arst_pre", score_out, 16'h0030);
        p0 = pulses;
        send(3'd4);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst_score", score_out, 16'h0000);
        check("arst_busy", busy, 1'b0);
        check("arst_ready", clear_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check("arst_pulses", pulses - p0, 0);
        check("arst_quiet_score", score_out, 16'h0000);

        // level
        do_reset();
        add_n(3'd1, 12);
        check("lvl_score", score_out, 16'h0120);
`ifdef SCORE_LEVEL_EN
        check("lvl_level", level, 4'h1);
`else
        check("lvl_level", level, 4'h0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
